overlap_add_mc: RTL

Parametrised, multi-channel overlap-add stage for the IMDCT back end of the decoder. It accepts IMDCT output blocks of 2·HALF_LEN signed samples per channel over a valid/ready stream. For each block it emits HALF_LEN PCM samples: the block's first half summed with the stored second half of that channel's previous block. It generalises the single-channel, fixed-width overlap with configurable sample width, half-block length, channel count, saturation and an end-of-block marker.

---
 rtl/overlap_add_mc.sv | 129 ++++++++++++
 1 files changed

// File: rtl/overlap_add_mc.sv
// overlap_add_mc
// Multi-channel overlap-add stage for the IMDCT back end.
// Each input block is 2*HALF_LEN signed samples for one channel. The first
// half of the block is summed with the stored second half of that channel's
// previous block and emitted as PCM. The second half of the block is stored
// as the new history for that channel.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_overlap_pcmSample       IMDCT sample (signed, DATA_W)
//   in_overlap_channel         block channel, sampled on the first beat only
//   in_overlap_firstSequence   first beat only: treat channel history as zero
//   in_overlap_valid/ready     input handshake
//   out_overlap_pcmSample      overlap-added PCM sample (signed, DATA_W)
//   out_overlap_channel        channel of the output sample
//   out_overlap_last           last output sample of a block
//   out_overlap_valid/ready    output handshake
module overlap_add_mc #(
   parameter int DATA_W   = 32,
   parameter int HALF_LEN = 18,
   parameter int CHANNELS = 2,
   parameter int SATURATE = 1,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] in_overlap_pcmSample,
   input  logic [CH_W-1:0]          in_overlap_channel,
   input  logic                     in_overlap_firstSequence,
   input  logic                     in_overlap_valid,
   output logic                     in_overlap_ready,
   output logic signed [DATA_W-1:0] out_overlap_pcmSample,
   output logic [CH_W-1:0]          out_overlap_channel,
   output logic                     out_overlap_last,
   output logic                     out_overlap_valid,
   input  logic                     out_overlap_ready
);

   localparam int A_W = (HALF_LEN > 1) ? $clog2(HALF_LEN) : 1;
   localparam logic [A_W-1:0] IDX_LAST = A_W'(HALF_LEN - 1);
   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Beat counter k is kept as {second_half, idx}: idx addresses the history
   // entry directly in both halves, so no subtraction is needed.
   logic                 second_half;
   logic [A_W-1:0]       idx;
   logic [CH_W-1:0]      cur_ch;
   logic                 cur_clear;
   logic [CHANNELS-1:0]  hist_valid;
   logic signed [DATA_W-1:0] hist [CHANNELS][HALF_LEN];

   logic                 accept;
   logic                 block_start;
   logic                 idx_wrap;
   logic [CH_W-1:0]      blk_ch;
   logic                 blk_clear;
   logic signed [DATA_W-1:0] hist_rd;
   logic [DATA_W:0]      sum_wide;
   logic [DATA_W-1:0]    sum_res;

   assign in_overlap_ready = second_half || !out_overlap_valid || out_overlap_ready;
   assign accept           = in_overlap_valid && in_overlap_ready;
   assign block_start      = !second_half && (idx == '0);
   assign idx_wrap         = (idx == IDX_LAST);

   // On the first beat the latched channel/clear are not yet loaded, so the
   // live inputs are used for that beat's history lookup.
   assign blk_ch    = block_start ? in_overlap_channel : cur_ch;
   assign blk_clear = block_start ? (in_overlap_firstSequence || !hist_valid[in_overlap_channel])
                                  : cur_clear;

   always_comb begin
      hist_rd  = blk_clear ? '0 : hist[blk_ch][idx];
      sum_wide = {in_overlap_pcmSample[DATA_W-1], in_overlap_pcmSample}
               + {hist_rd[DATA_W-1], hist_rd};
      sum_res  = sum_wide[DATA_W-1:0];
      // Overflow when the extra sign bit disagrees with the result sign.
      if ((SATURATE != 0) && (sum_wide[DATA_W] != sum_wide[DATA_W-1])) begin
         sum_res = sum_wide[DATA_W] ? SAT_MIN : SAT_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         second_half           <= 1'b0;
         idx                   <= '0;
         cur_ch                <= '0;
         cur_clear             <= 1'b0;
         hist_valid            <= '0;
         out_overlap_valid     <= 1'b0;
         out_overlap_pcmSample <= '0;
         out_overlap_channel   <= '0;
         out_overlap_last      <= 1'b0;
      end else begin
         if (out_overlap_valid && out_overlap_ready) begin
            out_overlap_valid <= 1'b0;
         end
         if (accept) begin
            if (idx_wrap) begin
               idx         <= '0;
               second_half <= !second_half;
            end else begin
               idx <= idx + 1'b1;
            end
            if (block_start) begin
               cur_ch    <= in_overlap_channel;
               cur_clear <= blk_clear;
            end
            if (!second_half) begin
               out_overlap_valid     <= 1'b1;
               out_overlap_pcmSample <= sum_res;
               out_overlap_channel   <= blk_ch;
               out_overlap_last      <= idx_wrap;
            end else if (idx_wrap) begin
               hist_valid[cur_ch] <= 1'b1;
            end
         end
      end
   end

   // History contents are deliberately not reset; hist_valid gates them.
   always_ff @(posedge clk) begin
      if (!reset && accept && second_half) begin
         hist[cur_ch][idx] <= in_overlap_pcmSample;
      end
   end

endmodule
